// File: rtl/fifteen.sv
// ---------------------------------------------------------------------------
// fifteen -- bidirectional shift register with parallel load, hold and a
// tri-state output (74x194-style function plus an active-low output enable).
//
// Ports
//   CLK    in   1      single clock, all state changes on the rising edge
//   RST_N  in   1      synchronous active-low reset, clears the register
//   OE     in   1      output enable, active-low (0 = drive Q, 1 = Q high-Z)
//   S      in   2      mode: 00 hold, 01 shift right, 10 shift left, 11 load
//   D      in   WIDTH  parallel data; D[WIDTH-1] is the shift-right serial-in,
//                      D[0] is the shift-left serial-in
//   Q      out  WIDTH  register contents, or high-Z when OE=1
//
// There is no handshake: every rising edge applies the selected mode, and the
// new register value appears on Q right after that edge.
// ---------------------------------------------------------------------------
module fifteen #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             OE,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r;

    // Reset wins over every mode. An unknown mode select lands in the default
    // branch, so the register simply holds.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r <= '0;
        end else begin
            case (S)
                2'b01:   r <= {D[WIDTH-1], r[WIDTH-1:1]};
                2'b10:   r <= {r[WIDTH-2:0], D[0]};
                2'b11:   r <= D;
                default: r <= r;
            endcase
        end
    end

    // Output enable gates only the bus driver; the register keeps updating
    // while Q floats, so re-enabling shows the current value immediately.
    assign Q = OE ? {WIDTH{1'bz}} : r;

endmodule

// File: tb/tb_fifteen.sv
// ---------------------------------------------------------------------------
// tb_fifteen -- self-checking bench for fifteen (WIDTH = 4).
// Driver tasks apply inputs on the falling edge and push the hand-computed
// expected Q into a scoreboard queue; the monitor pops and compares 1 ns after
// each sample point (rising edge, or an OE-only change).
// ---------------------------------------------------------------------------
module tb_fifteen;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         oe = 1'b0;
    logic [1:0]   s = 2'b00;
    logic [W-1:0] d = '0;
    wire  [W-1:0] q;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    bit           exp_z_q[$];
    string        name_q[$];
    int           total = 0;
    int           bad = 0;
    event         chk_ev;

    fifteen #(.WIDTH(W)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .OE   (oe),
        .S    (s),
        .D    (d),
        .Q    (q)
    );

    // Clock: 20 ns period
    always #10 clk = ~clk;

    // Monitor: compare 1 ns after each sample point
    initial begin
        logic [W-1:0] e;
        bit           ez;
        string        nm;
        bit           ok;
        forever begin
            @(chk_ev);
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sample: no expectation queued, q=%b", q);
            end else begin
                e  = exp_q.pop_front();
                ez = exp_z_q.pop_front();
                nm = name_q.pop_front();
                if (ez) ok = (q === 4'bzzzz);
                else    ok = (q === e);
                total++;
                if (!ok) begin
                    bad++;
                    if (ez) $display("FAIL %s: q=%b expected=zzzz", nm, q);
                    else    $display("FAIL %s: q=%b expected=%b", nm, q, e);
                end
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] e, input bit ez, input string nm);
        exp_q.push_back(e);
        exp_z_q.push_back(ez);
        name_q.push_back(nm);
    endtask

    // One clock edge with the given inputs, then check Q after the edge
    task automatic step(input logic rn, input logic o, input logic [1:0] sm,
                        input logic [W-1:0] dv, input logic [W-1:0] e,
                        input bit ez, input string nm);
        @(negedge clk);
        rst_n = rn;
        oe    = o;
        s     = sm;
        d     = dv;
        @(posedge clk);
        push_exp(e, ez, nm);
        -> chk_ev;
    endtask

    // Change only OE between edges and check Q without a clock edge
    task automatic set_oe(input logic o, input logic [W-1:0] e, input bit ez,
                          input string nm);
        @(negedge clk);
        oe = o;
        push_exp(e, ez, nm);
        -> chk_ev;
    endtask

    initial begin
        // 1. Reset, including reset priority over load
        step(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0, "reset");
        step(1'b0, 1'b0, 2'b11, 4'b1111, 4'b0000, 1'b0, "reset_over_load");

        // 2. Load then shift left (serial-in D[0]=0)
        step(1'b1, 1'b0, 2'b11, 4'b1000, 4'b1000, 1'b0, "load_1000");
        step(1'b1, 1'b0, 2'b10, 4'b0000, 4'b0000, 1'b0, "shl_msb_lost");
        step(1'b1, 1'b0, 2'b11, 4'b0001, 4'b0001, 1'b0, "load_0001");
        step(1'b1, 1'b0, 2'b10, 4'b0000, 4'b0010, 1'b0, "shl_1");
        step(1'b1, 1'b0, 2'b10, 4'b0000, 4'b0100, 1'b0, "shl_2");
        step(1'b1, 1'b0, 2'b10, 4'b0000, 4'b1000, 1'b0, "shl_3");
        step(1'b1, 1'b0, 2'b10, 4'b0000, 4'b0000, 1'b0, "shl_4");
        // Shift left with serial-in 1 (D[0]=1, other D bits 0)
        step(1'b1, 1'b0, 2'b10, 4'b0001, 4'b0001, 1'b0, "shl_sin_1");
        step(1'b1, 1'b0, 2'b10, 4'b0001, 4'b0011, 1'b0, "shl_sin_2");

        // 3. Shift right with serial-in 0, then serial-in 1 (D[3]=1)
        step(1'b1, 1'b0, 2'b11, 4'b1000, 4'b1000, 1'b0, "load_1000_b");
        step(1'b1, 1'b0, 2'b01, 4'b0000, 4'b0100, 1'b0, "shr_1");
        step(1'b1, 1'b0, 2'b01, 4'b0000, 4'b0010, 1'b0, "shr_2");
        step(1'b1, 1'b0, 2'b01, 4'b0000, 4'b0001, 1'b0, "shr_3");
        step(1'b1, 1'b0, 2'b01, 4'b0000, 4'b0000, 1'b0, "shr_4");
        step(1'b1, 1'b0, 2'b11, 4'b1000, 4'b1000, 1'b0, "load_1000_c");
        step(1'b1, 1'b0, 2'b01, 4'b1000, 4'b1100, 1'b0, "shr_sin_1");
        step(1'b1, 1'b0, 2'b01, 4'b1000, 4'b1110, 1'b0, "shr_sin_2");
        step(1'b1, 1'b0, 2'b01, 4'b1000, 4'b1111, 1'b0, "shr_sin_3");

        // 4. Hold with output disabled, D toggling to show it is ignored
        step(1'b1, 1'b0, 2'b11, 4'b1010, 4'b1010, 1'b0, "load_1010");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 2'b00, (i % 2 == 0) ? 4'b0101 : 4'b1111,
                 4'b0000, 1'b1, "hold_hiz");
        end
        set_oe(1'b0, 4'b1010, 1'b0, "hold_reenable");

        // 5. Register updates while output is high-Z
        step(1'b1, 1'b0, 2'b11, 4'b0001, 4'b0001, 1'b0, "load_0001_b");
        set_oe(1'b1, 4'b0000, 1'b1, "oe_off_no_edge");
        step(1'b1, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b1, "shl_hiz_1");
        step(1'b1, 1'b1, 2'b10, 4'b0000, 4'b0000, 1'b1, "shl_hiz_2");
        set_oe(1'b0, 4'b0100, 1'b0, "hiz_reenable");

        // 6. Mode switch mid-stream
        step(1'b1, 1'b0, 2'b11, 4'b0001, 4'b0001, 1'b0, "load_0001_c");
        step(1'b1, 1'b0, 2'b01, 4'b0000, 4'b0000, 1'b0, "shr_out");
        step(1'b1, 1'b0, 2'b11, 4'b0110, 4'b0110, 1'b0, "load_0110");

        // Reset does not gate the output: high-Z under OE=1, then 0000
        step(1'b0, 1'b1, 2'b11, 4'b1111, 4'b0000, 1'b1, "reset_hiz");
        set_oe(1'b0, 4'b0000, 1'b0, "reset_reenable");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
